mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (read-only) and the MEM stage (read/write) of the 5-stage pipeline.
- Arbitrates between the two, sequences each access with a latency counter, and returns registered read data with a one-cycle done pulse.
- Drives per-port stall signals that the pipeline hazard logic uses to freeze IF or MEM.

Parameters:
- LATENCY, 2, memory access cycles per transaction; legal range 1..15.
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win; used only with the optional feature.

Ports:
- CLK  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  64  fetch address; stable while if_req
- if_done  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  registered instruction, taken from mem_rdata[31:0]
- if_stall  out  1  if_req & ~if_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  64  data address
- d_wdata  in  64  write data
- d_done  out  1  one-cycle pulse
- d_rdata  out  64  registered read data; holds value after a write
- d_stall  out  1  d_req & ~d_done
- mem_en  out  1  memory select
- mem_we  out  1  memory write strobe
- mem_addr  out  64  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data; valid in the last ACCESS cycle

Behaviour:
- States: IDLE, ACCESS, RESP. The state register is 2 bits.
- Reset values:
  - state = IDLE, cnt = 0, owner = NONE.
  - if_done = d_done = 0; if_rdata = 0; d_rdata = 0.
  - All mem_* outputs = 0.
- IDLE, arbitration happens only here:
  - d_req wins over if_req; the MEM stage is older.
  - On a grant, latch owner, address, we and wdata; set cnt = LATENCY-1; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_addr and mem_wdata come from the latched values.
  - mem_we = latched we AND (cnt == 0), so each write commits exactly once.
  - cnt decrements each cycle. When cnt == 0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - The owner's done = 1 for exactly this cycle; the non-owner's done stays 0.
  - Go to IDLE.
- Latency: a request seen in IDLE at cycle t gives done at cycle t+LATENCY+1. Throughput is one transaction per LATENCY+2 cycles.
- A requester still asserting req in the cycle after its done is a new request.
- A request dropped mid-transaction is a protocol violation. The transaction still completes and still pulses done.
- Simultaneous requests: data is served first, and fetch is granted in the IDLE cycle that follows RESP.
- Stall outputs:
  - A port that has won its grant keeps stall high through ACCESS.
  - A port that lost arbitration keeps stall high the whole time it is waiting.
- Reset mid-operation:
  - Next state = IDLE, with no done pulse.
  - All mem_* outputs are gated low while reset = 1, so no write commits in the reset cycle.
  - The rdata registers clear to 0.
- A write in RESP leaves d_rdata unchanged.
- cnt width is 4 bits. LATENCY = 1 means one ACCESS cycle with cnt = 0.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STARVE_GUARD_EN.
- Defined:
  - A 4-bit starve_cnt increments on every IDLE grant to data while if_req = 1, saturating at 15.
  - When starve_cnt >= STARVE_LIMIT, fetch wins the next simultaneous arbitration.
  - starve_cnt clears on any fetch grant and on reset.
- Undefined: fixed data priority; starve_cnt and its logic are absent.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - the state enum (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - the owner enum (NONE, FETCH, DATA);
  - CNT_W = 4.
- One sub-module, mem_port_latency_counter:
  - inputs: load, load value, decrement enable;
  - output: zero flag.
- Arbitration and the FSM stay in the top module.

Test Plan (all with LATENCY=2):
- Fetch only: if_req=1 at cycle 0, if_addr=0x40, mem_rdata=0xF84003E9 → mem_en high in cycles 1-2; if_done=1 at cycle 3 only; if_rdata=0xF84003E9; if_stall=1 in cycles 0-2 and 0 at cycle 3.
- Data write: d_req=1, d_we=1, d_addr=0x80, d_wdata=0x1234 at cycle 0 → mem_we=1 only in cycle 2 with mem_wdata=0x1234; d_done at cycle 3; d_rdata unchanged.
- Simultaneous: d_req (read 0x100 → 0xAA) and if_req (0x44) at cycle 0 → d_done at cycle 3 with d_rdata=0xAA; fetch granted at cycle 4; if_done at cycle 7; if_stall=1 for cycles 0-6.
- Reset mid-write: write issued at cycle 0, reset=1 at cycle 2 → mem_we=0 in cycle 2; state IDLE at cycle 3; no d_done; all outputs 0.
- Back-to-back: d_req held high through its done at cycle 3 → second grant at cycle 4; second d_done at cycle 7.
- Starve guard (macro defined, STARVE_LIMIT=2): if_req held high while d_req re-asserts every IDLE cycle → data wins 2 grants; the third simultaneous IDLE grant goes to fetch. With the macro undefined, fetch never wins while d_req stays high.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM state encoding, the transaction owner encoding and the
// latency counter width. Imported by mem_port_arbiter and
// mem_port_latency_counter.
package mem_port_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mem_port_latency_counter.sv
// Down-counter that sequences the ACCESS phase of one memory transaction.
// Ports:
//   CLK      - clock, all state changes on posedge
//   reset    - synchronous active-high reset, clears the count
//   load     - load load_val (takes priority over dec)
//   load_val - initial count, LATENCY-1
//   dec      - decrement enable; the count holds at zero
//   zero     - count is zero (last ACCESS cycle)
module mem_port_latency_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins over decrement, decrement stops at zero.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port fixed-latency memory between the fetch
// stage (read-only) and the MEM stage (read/write).
// Arbitration happens only in IDLE; data wins over fetch. Each granted
// transaction spends LATENCY cycles in ACCESS and one cycle in RESP, where
// the owner's done pulses with registered read data.
// Optional feature: define MEM_PORT_ARBITER_STARVE_GUARD_EN to add a fetch
// starvation guard (fetch wins once it has lost STARVE_LIMIT data grants).
// Ports:
//   CLK, reset                     - clock, synchronous active-high reset
//   if_req/if_addr                 - fetch request and address
//   if_done/if_rdata/if_stall      - fetch completion, instruction, stall
//   d_req/d_we/d_addr/d_wdata      - data request, write flag, address, data
//   d_done/d_rdata/d_stall         - data completion, read data, stall
//   mem_en/mem_we/mem_addr/mem_wdata - memory command (gated low in reset)
//   mem_rdata                      - memory read data, valid in last ACCESS
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LATENCY = 2
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
)(
    input  logic        CLK,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic [63:0] d_rdata,
    output logic        d_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    arb_state_t  state_r;
    arb_state_t  state_nx_s;
    arb_owner_t  owner_r;
    arb_owner_t  grant_s;
    logic [63:0] addr_r;
    logic        we_r;
    logic [63:0] wdata_r;
    logic        if_done_r;
    logic        d_done_r;
    logic [31:0] if_rdata_r;
    logic [63:0] d_rdata_r;
    logic        load_s;
    logic        dec_s;
    logic        fin_s;
    logic        cnt_zero_s;
    logic        fetch_pri_s;
    logic        access_s;

    mem_port_latency_counter u_cnt (
        .CLK      (CLK),
        .reset    (reset),
        .load     (load_s),
        .load_val (LOAD_VAL),
        .dec      (dec_s),
        .zero     (cnt_zero_s)
    );

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt_r;

    // Starvation counter: counts data grants taken while fetch was waiting.
    always_ff @(posedge CLK) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (load_s && (grant_s == FETCH)) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (load_s && (grant_s == DATA) && if_req &&
                     (starve_cnt_r != {CNT_W{1'b1}})) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign fetch_pri_s = if_req && (starve_cnt_r >= CNT_W'(STARVE_LIMIT));
`else
    assign fetch_pri_s = 1'b0;
`endif

    // Next-state logic: arbitration in IDLE, latency sequencing in ACCESS.
    always_comb begin
        state_nx_s = state_r;
        grant_s    = NONE;
        load_s     = 1'b0;
        dec_s      = 1'b0;
        fin_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req && !fetch_pri_s) begin
                    grant_s = DATA;
                end else if (if_req) begin
                    grant_s = FETCH;
                end else begin
                    grant_s = NONE;
                end
                if (grant_s != NONE) begin
                    load_s     = 1'b1;
                    state_nx_s = ACCESS;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_zero_s) begin
                    fin_s      = 1'b1;
                    state_nx_s = RESP;
                end else begin
                    dec_s      = 1'b1;
                    state_nx_s = ACCESS;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, latched transaction and registered response outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r    <= IDLE;
            owner_r    <= NONE;
            addr_r     <= 64'd0;
            we_r       <= 1'b0;
            wdata_r    <= 64'd0;
            if_done_r  <= 1'b0;
            d_done_r   <= 1'b0;
            if_rdata_r <= 32'd0;
            d_rdata_r  <= 64'd0;
        end else begin
            state_r <= state_nx_s;
            if (load_s) begin
                owner_r <= grant_s;
                addr_r  <= (grant_s == DATA) ? d_addr : if_addr;
                we_r    <= (grant_s == DATA) && d_we;
                wdata_r <= (grant_s == DATA) ? d_wdata : 64'd0;
            end else begin
                owner_r <= owner_r;
                addr_r  <= addr_r;
                we_r    <= we_r;
                wdata_r <= wdata_r;
            end
            if_done_r <= fin_s && (owner_r == FETCH);
            d_done_r  <= fin_s && (owner_r == DATA);
            if (fin_s && (owner_r == FETCH)) begin
                if_rdata_r <= mem_rdata[31:0];
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            // A write completes without disturbing the last read value.
            if (fin_s && (owner_r == DATA) && !we_r) begin
                d_rdata_r <= mem_rdata;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    // Reset gates the memory command so nothing commits in the reset cycle.
    assign access_s  = (state_r == ACCESS) && !reset;
    assign mem_en    = access_s;
    assign mem_we    = access_s && we_r && cnt_zero_s;
    assign mem_addr  = access_s ? addr_r : 64'd0;
    assign mem_wdata = access_s ? wdata_r : 64'd0;

    assign if_done  = if_done_r;
    assign d_done   = d_done_r;
    assign if_rdata = if_rdata_r;
    assign d_rdata  = d_rdata_r;
    assign if_stall = if_req && !if_done_r;
    assign d_stall  = d_req && !d_done_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (LATENCY = 2). A transaction-level
// timeline model predicts every output each cycle; directed scenarios add
// explicit constant checks, followed by randomized request traffic.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam int SL = 2;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = 64'd0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = 64'd0;
    logic [63:0] d_wdata = 64'd0;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .LATENCY(LAT)
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        , .STARVE_LIMIT(SL)
`endif
    ) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Timeline model: one transaction granted at g_cyc owns the memory for
    // cycles g_cyc+1..g_cyc+LAT and pulses done at g_cyc+LAT+1.
    int          cyc = 0;
    int          idle_at = 0;
    int          g_cyc = -100;
    bit          active = 1'b0;
    int          g_own = 0;
    logic        g_we = 1'b0;
    logic [63:0] g_addr = 64'd0;
    logic [63:0] g_wdata = 64'd0;
    logic [31:0] m_if_rdata = 32'd0;
    logic [63:0] m_d_rdata = 64'd0;
    bit          chk_on = 1'b0;
    int          starve = 0;
    bit          last_ifd = 1'b0;
    bit          last_dd = 1'b0;

    logic        if_pend = 1'b0;
    logic [63:0] if_a = 64'd0;
    logic        d_pend = 1'b0;
    logic        d_w = 1'b0;
    logic [63:0] d_a = 64'd0;
    logic [63:0] d_wd = 64'd0;

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        if (a == 64'h40) return 64'h0000_0000_F840_03E9;
        else if (a == 64'h100) return 64'h0000_0000_0000_00AA;
        else return {a[31:0] ^ 32'hC3D2_E1F0, a[63:32] + a[31:0] + 32'h1357_9BDF};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", tag, cyc, act, expv);
        end
    endtask

    task automatic step(input logic rst, input logic ir, input logic [63:0] ia,
                        input logic dr, input logic dw, input logic [63:0] da,
                        input logic [63:0] dwd);
        logic        exp_en, exp_we, exp_ifd, exp_dd, fetch_first;
        logic [63:0] mv;
        @(posedge CLK);
        #1;
        reset = rst; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        @(negedge CLK);
        exp_en  = active && !rst && (cyc > g_cyc) && (cyc <= g_cyc + LAT);
        exp_we  = exp_en && g_we && (cyc == g_cyc + LAT);
        exp_ifd = active && (g_own == 1) && (cyc == g_cyc + LAT + 1);
        exp_dd  = active && (g_own == 2) && (cyc == g_cyc + LAT + 1);
        mv = mem_val(g_addr);
        if (exp_ifd) m_if_rdata = mv[31:0];
        if (exp_dd && !g_we) m_d_rdata = mv;
        if (chk_on) begin
            chk("mem_en", 64'(mem_en), 64'(exp_en));
            chk("mem_we", 64'(mem_we), 64'(exp_we));
            chk("mem_addr", mem_addr, exp_en ? g_addr : 64'd0);
            if (exp_we || !exp_en) chk("mem_wdata", mem_wdata, exp_en ? g_wdata : 64'd0);
            chk("if_done", 64'(if_done), 64'(exp_ifd));
            chk("d_done", 64'(d_done), 64'(exp_dd));
            chk("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
            chk("d_rdata", d_rdata, m_d_rdata);
            chk("if_stall", 64'(if_stall), 64'(ir && !exp_ifd));
            chk("d_stall", 64'(d_stall), 64'(dr && !exp_dd));
        end
        last_ifd = exp_ifd;
        last_dd  = exp_dd;
        mem_rdata = (exp_en && (cyc == g_cyc + LAT)) ? mv : {$urandom, $urandom};
        if (rst) begin
            active = 1'b0;
            idle_at = cyc + 1;
            m_if_rdata = 32'd0;
            m_d_rdata = 64'd0;
            starve = 0;
            chk_on = 1'b1;
        end else if (cyc >= idle_at) begin
            fetch_first = 1'b0;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
            fetch_first = ir && (starve >= SL);
`endif
            if (dr && !fetch_first) begin
                active = 1'b1; g_cyc = cyc; idle_at = cyc + LAT + 2;
                g_own = 2; g_we = dw; g_addr = da; g_wdata = dwd;
                if (ir && starve < 15) starve++;
            end else if (ir) begin
                active = 1'b1; g_cyc = cyc; idle_at = cyc + LAT + 2;
                g_own = 1; g_we = 1'b0; g_addr = ia; g_wdata = 64'd0;
                starve = 0;
            end
        end
        cyc++;
    endtask

    initial begin
        int ifd_cnt;
        int dd_cnt;
        bit rst_b;

        // Reset and reset state.
        step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("rst_if_done", 64'(if_done), 64'd0);
        chk("rst_d_done", 64'(d_done), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);

        // Fetch only.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 64'h40, 1'b0, 1'b0, 64'd0, 64'd0);
            if (k < 3) chk("fo_stall", 64'(if_stall), 64'd1);
            if (k == 1 || k == 2) chk("fo_en", 64'(mem_en), 64'd1);
            if (k == 3) begin
                chk("fo_done", 64'(if_done), 64'd1);
                chk("fo_rdata", 64'(if_rdata), 64'h0000_0000_F840_03E9);
                chk("fo_stall3", 64'(if_stall), 64'd0);
            end
        end
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("fo_done_once", 64'(if_done), 64'd0);

        // Simultaneous requests: data first, then fetch.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 64'h44, (k <= 3), 1'b0, 64'h100, 64'd0);
            if (k == 3) begin
                chk("sim_d_done", 64'(d_done), 64'd1);
                chk("sim_d_rdata", d_rdata, 64'hAA);
            end
            if (k == 4) chk("sim_gap_en", 64'(mem_en), 64'd0);
            if (k == 5) chk("sim_f_addr", mem_addr, 64'h44);
            if (k <= 6) chk("sim_if_stall", 64'(if_stall), 64'd1);
            if (k == 7) chk("sim_if_done", 64'(if_done), 64'd1);
        end
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Data write commits once, read data held.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h80, 64'h1234);
            if (k == 1) chk("wr_we1", 64'(mem_we), 64'd0);
            if (k == 2) begin
                chk("wr_we2", 64'(mem_we), 64'd1);
                chk("wr_wdata", mem_wdata, 64'h1234);
                chk("wr_addr", mem_addr, 64'h80);
            end
            if (k == 3) begin
                chk("wr_done", 64'(d_done), 64'd1);
                chk("wr_rdata_hold", d_rdata, 64'hAA);
            end
        end
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Back-to-back data reads.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'h100, 64'd0);
            if (k == 3) chk("b2b_done1", 64'(d_done), 64'd1);
            if (k == 4) begin
                chk("b2b_gap_done", 64'(d_done), 64'd0);
                chk("b2b_gap_stall", 64'(d_stall), 64'd1);
                chk("b2b_gap_en", 64'(mem_en), 64'd0);
            end
            if (k == 5) chk("b2b_en2", 64'(mem_en), 64'd1);
            if (k == 7) chk("b2b_done2", 64'(d_done), 64'd1);
        end
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Reset in the committing cycle of a write.
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h80, 64'h5678);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h80, 64'h5678);
        step(1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 64'h80, 64'h5678);
        chk("rmw_we", 64'(mem_we), 64'd0);
        chk("rmw_en", 64'(mem_en), 64'd0);
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("rmw_d_done", 64'(d_done), 64'd0);
        chk("rmw_en_after", 64'(mem_en), 64'd0);
        chk("rmw_if_rdata", 64'(if_rdata), 64'd0);
        chk("rmw_d_rdata", d_rdata, 64'd0);
        chk("rmw_d_stall", 64'(d_stall), 64'd0);
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("rmw_no_done", 64'(d_done), 64'd0);

        // Fetch held against continuous data traffic.
        ifd_cnt = 0;
        dd_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 64'h200, 1'b1, 1'b0, 64'h300, 64'd0);
            ifd_cnt += int'(if_done);
            dd_cnt += int'(d_done);
        end
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        chk("starve_if_dones", 64'(ifd_cnt), 64'd1);
        chk("starve_d_dones", 64'(dd_cnt), 64'd4);
`else
        chk("starve_if_dones", 64'(ifd_cnt), 64'd0);
        chk("starve_d_dones", 64'(dd_cnt), 64'd5);
`endif
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            rst_b = ($urandom_range(0, 199) == 0);
            if (rst_b) begin
                if_pend = 1'b0;
                d_pend = 1'b0;
            end else begin
                if (if_pend && last_ifd) begin
                    if_pend = ($urandom_range(0, 1) == 1);
                    if_a = {$urandom, $urandom};
                end else if (!if_pend) begin
                    if_pend = ($urandom_range(0, 2) == 0);
                    if_a = {$urandom, $urandom};
                end
                if ((d_pend && last_dd) || !d_pend) begin
                    d_pend = d_pend ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                    d_w = ($urandom_range(0, 1) == 1);
                    d_a = {$urandom, $urandom};
                    d_wd = {$urandom, $urandom};
                end
            end
            step(rst_b, if_pend, if_a, d_pend, d_w, d_a, d_wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
